// File: rtl/dct_coeff_accum.sv
// Purpose : one 2-D DCT coefficient per 8x8 block: sum of pixel * cos_term, rounded and rescaled.
// Latency : coef_valid rises the cycle after the 64th pixel handshake; one pixel per cycle.
// Backpr. : pix_ready drops while a coefficient waits; it is held stable until coef_ready.
//
// Ports:
//   clk, reset                   - single clock, synchronous active-high reset
//   pix_valid/pix_ready/pix_data - unsigned pixel stream, raster order
//   n1, n2                       - row/column index driven to the cosine LUT
//   cos_term                     - signed fixed-point LUT value, combinational in n1/n2
//   coef_valid/coef_ready/coef_data - signed rounded coefficient output
//
// Optional feature: define DCT_LEVEL_SHIFT_EN to subtract 2^(PIX_W-1) from every
// pixel (JPEG level shift); otherwise pixels are used zero-extended.
module dct_coeff_accum #(
    parameter int PIX_W      = 8,
    parameter int ACC_W      = 32,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [PIX_W-1:0]        pix_data,
    output logic [2:0]              n1,
    output logic [2:0]              n2,
    input  logic signed [31:0]      cos_term,
    output logic                    coef_valid,
    input  logic                    coef_ready,
    output logic signed [ACC_W-1:0] coef_data
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Half an output LSB, added before the arithmetic shift (round half toward +inf).
    localparam logic [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [5:0]              r_idx;
    logic                    r_coef_valid;
    logic signed [ACC_W-1:0] r_coef;

    logic                    w_pix_rdy;
    logic                    w_pix_hs;
    logic                    w_coef_hs;
    logic                    w_last_pix;
    logic signed [PIX_W:0]   w_s;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_round;
    logic signed [ACC_W-1:0] w_coef;

`ifdef DCT_LEVEL_SHIFT_EN
    localparam logic [PIX_W:0] LVL_OFS = {2'b01, {(PIX_W-1){1'b0}}};
    assign w_s = $signed({1'b0, pix_data} - LVL_OFS);
`else
    assign w_s = $signed({1'b0, pix_data});
`endif

    // Only the low ACC_W bits of the product are kept, and those depend only on the
    // low ACC_W bits of each operand, so the multiply is done directly at ACC_W.
    assign w_prod  = ACC_W'(w_s) * ACC_W'(cos_term);
    assign w_sum   = r_acc + w_prod;
    assign w_round = w_sum + $signed(RND_HALF);
    assign w_coef  = w_round >>> FRAC_SHIFT;

    assign w_pix_hs   = pix_valid & w_pix_rdy;
    assign w_coef_hs  = r_coef_valid & coef_ready;
    assign w_last_pix = (r_idx == 6'd63);

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_pix_rdy    = 1'b0;
        case (r_state)
            ACCUM: begin
                w_pix_rdy = ~reset;
                if (w_pix_hs && w_last_pix) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (w_coef_hs) begin
                    w_next_state = ACCUM;
                end
            end
            default: w_next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ACCUM;
            r_acc        <= '0;
            r_idx        <= '0;
            r_coef_valid <= 1'b0;
            r_coef       <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pix_hs) begin
                r_acc <= w_sum;
                if (w_last_pix) begin
                    // idx stays at 63 so the LUT index reads 7/7 while holding.
                    r_coef       <= w_coef;
                    r_coef_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + 6'd1;
                end
            end
            if (w_coef_hs) begin
                r_acc        <= '0;
                r_idx        <= '0;
                r_coef_valid <= 1'b0;
            end
        end
    end

    assign pix_ready  = w_pix_rdy;
    assign n1         = r_idx[5:3];
    assign n2         = r_idx[2:0];
    assign coef_valid = r_coef_valid;
    assign coef_data  = r_coef;

endmodule

// File: tb/tb_dct_coeff_accum.sv
// Purpose : randomized and directed check of dct_coeff_accum against a dot-product model.
// Latency : bench drives at posedge+1, samples at negedge or posedge+1.
// Backpr. : exercises coef_ready stalls, tied-high coef_ready and pix_valid gaps.
module tb_dct_coeff_accum;

    logic               clk = 1'b0;
    logic               reset;
    logic               pix_valid;
    logic               pix_ready;
    logic [7:0]         pix_data;
    logic [2:0]         n1;
    logic [2:0]         n2;
    logic signed [31:0] cos_term;
    logic               coef_valid;
    logic               coef_ready;
    logic signed [31:0] coef_data;

    int lut [64];
    int blk [64];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dct_coeff_accum dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .n1         (n1),
        .n2         (n2),
        .cos_term   (cos_term),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data)
    );

    // k1=5, k2=7 cosine LUT, 8 fractional bits, truncated toward zero.
    assign cos_term = lut[{n1, n2}];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: dot product of level-shifted pixels with the LUT, wrapped to 32 bits,
    // then (acc + 128) >>> 8.
    function automatic int model();
        longint acc = 0;
        int     a32;
        int     s;
        for (int i = 0; i < 64; i++) begin
`ifdef DCT_LEVEL_SHIFT_EN
            s = blk[i] - 128;
`else
            s = blk[i];
`endif
            acc += longint'(s) * longint'(lut[i]);
        end
        a32 = int'(acc);
        a32 = a32 + 128;
        return a32 >>> 8;
    endfunction

    task automatic fill(input int base, input int pos, input int val);
        for (int i = 0; i < 64; i++) blk[i] = base;
        if (pos >= 0) blk[pos] = val;
    endtask

    // Starts and ends at posedge+1. Sends npix pixels of blk with random gaps.
    task automatic send_block(input int npix, input int gap_pct, input bit rdy_high);
        int k   = 0;
        int cyc = 0;
        coef_ready = rdy_high;
        while (k < npix && cyc < 2000) begin
            if ($urandom_range(99) < gap_pct) begin
                pix_valid = 1'b0;
                pix_data  = 8'($urandom);
            end else begin
                pix_valid = 1'b1;
                pix_data  = 8'(blk[k]);
            end
            @(negedge clk);
            if (pix_valid && pix_ready) begin
                chk("idx_n1", n1, k >> 3);
                chk("idx_n2", n2, k & 7);
                if (k == 63) chk("valid_before_last", coef_valid, 0);
                k++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 2000) chk("pix_timeout", 0, 1);
        pix_valid = 1'b0;
        if (npix == 64) begin
            chk("valid_latency", coef_valid, 1);
            chk("rdy_in_hold", pix_ready, 0);
            chk("hold_n1", n1, 7);
            chk("hold_n2", n2, 7);
        end
    endtask

    // Starts right after the last accept; stalls hold cycles, then handshakes.
    task automatic take_coef(input int hold, input int exp, input string tag);
        chk(tag, coef_data, exp);
        for (int h = 0; h < hold; h++) begin
            coef_ready = 1'b0;
            pix_valid  = 1'b1;
            pix_data   = 8'($urandom);
            @(negedge clk);
            chk("stall_valid", coef_valid, 1);
            chk("stall_data", coef_data, exp);
            chk("stall_pix_rdy", pix_ready, 0);
            chk("stall_n2", n2, 7);
            @(posedge clk);
            #1;
        end
        pix_valid  = 1'b0;
        coef_ready = 1'b1;
        @(negedge clk);
        chk("hs_valid", coef_valid, 1);
        chk("hs_data", coef_data, exp);
        @(posedge clk);
        #1;
        coef_ready = 1'b0;
        chk("post_valid", coef_valid, 0);
        chk("post_pix_rdy", pix_ready, 1);
        chk("post_n1", n1, 0);
        chk("post_n2", n2, 0);
    endtask

    task automatic do_reset(input int cycles);
        reset     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'd55;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk("rst_pix_rdy", pix_ready, 0);
            @(posedge clk);
            #1;
        end
        reset     = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        chk("rst_pix_rdy_after", pix_ready, 1);
        chk("rst_valid", coef_valid, 0);
        chk("rst_data", coef_data, 0);
        chk("rst_n1", n1, 0);
        chk("rst_n2", n2, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        real pi;
        int  e;
        pi = 3.14159265358979323846;
        for (int i = 0; i < 64; i++) begin
            lut[i] = $rtoi(256.0 * $cos(real'((2 * (i >> 3) + 1) * 5) * pi / 16.0)
                                 * $cos(real'((2 * (i & 7) + 1) * 7) * pi / 16.0));
        end
        reset      = 1'b1;
        pix_valid  = 1'b0;
        pix_data   = '0;
        coef_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);

`ifdef DCT_LEVEL_SHIFT_EN
        fill(128, -1, 0);   send_block(64, 0, 0); take_coef(0, 0, "flat");
        fill(128, 0, 200);  send_block(64, 0, 0); take_coef(0, 8, "bright_idx0");
        fill(128, 11, 255); send_block(64, 0, 0); take_coef(5, 122, "bright_idx11");
        fill(128, 9, 0);    send_block(64, 0, 0); take_coef(0, -69, "neg_idx9");
        fill(128, 10, 0);   send_block(64, 0, 1); take_coef(0, 104, "dark_idx10");
        fill(128, -1, 0);   send_block(30, 0, 0); do_reset(2);
        send_block(64, 0, 0); take_coef(0, 0, "flat_after_reset");
`else
        fill(1, -1, 0);     send_block(64, 0, 0); take_coef(0, 0, "ones");
        fill(0, 0, 255);    send_block(64, 0, 0); take_coef(5, 27, "bright_idx0");
        fill(0, 20, 255);   send_block(30, 0, 0); do_reset(2);
        fill(1, -1, 0);     send_block(64, 0, 1); take_coef(0, 0, "ones_after_reset");
`endif

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(255));
            e = model();
            send_block(64, 0, t[0]);
            take_coef(int'($urandom_range(6)), e, "rand_nogap");
            send_block(64, 40, 0);
            take_coef(int'($urandom_range(3)), e, "rand_gaps");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
